// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the CPU data port and data memory, with store-to-load forwarding
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    input  logic                     cpu_wr,
    input  logic                     cpu_sb,
    input  logic                     cpu_sh,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_stall,
    output logic [31:0]              mem_raddr,
    input  logic [31:0]              mem_rdata,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [31:0]              mem_waddr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wbe,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    addr_d [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    data_d [DEPTH];
    logic [3:0]     be_q   [DEPTH];
    logic [3:0]     be_d   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           full, enq, deq;
    logic [3:0]     st_be;
    logic [31:0]    st_data;
    logic [31:0]    fwd_data;
    logic [PW-1:0]  idx;

    assign full       = level_q == LW'(DEPTH);
    assign enq        = cpu_wr && !full;
    assign mem_wvalid = level_q != '0;
    assign deq        = mem_wvalid && mem_wready;
    assign cpu_stall  = cpu_wr && full;
    assign level      = level_q;
    assign mem_raddr  = {cpu_addr[31:2], 2'b00};
    assign mem_waddr  = mem_wvalid ? addr_q[rd_ptr_q] : '0;
    assign mem_wdata  = mem_wvalid ? data_q[rd_ptr_q] : '0;
    assign mem_wbe    = mem_wvalid ? be_q[rd_ptr_q]   : '0;
    assign cpu_rdata  = FWD_EN ? fwd_data : mem_rdata;

    // Place the store into its byte lanes; byte address 0 is the most significant lane
    always_comb begin
        st_be   = cpu_sb ? (4'b1000 >> cpu_addr[1:0]) : cpu_sh ? (cpu_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        st_data = cpu_sb ? {4{cpu_wdata[7:0]}} : cpu_sh ? {2{cpu_wdata[15:0]}} : cpu_wdata;
    end

    // Overlay buffered bytes onto the memory word, oldest first so the newest store wins
    always_comb begin
        fwd_data = mem_rdata;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == mem_raddr)
                for (int b = 0; b < 4; b++)
                    if (be_q[idx][b]) fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
        end
    end

    // Next-state for entries, pointers and occupancy
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LW'(enq) - LW'(deq);
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            addr_d[wr_ptr_q]  = {cpu_addr[31:2], 2'b00};
            data_d[wr_ptr_q]  = st_data;
            be_d[wr_ptr_q]    = st_be;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
    end

    // State registers; reset discards any in-flight entries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule
